// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: register offsets, channel count and channel FSM encoding
package pwm_capture_pkg;
    localparam int NCH = 4;
    localparam logic [31:0] OFF_CTRL    = 32'h00;
    localparam logic [31:0] OFF_STATUS  = 32'h04;
    localparam logic [31:0] OFF_PERIOD0 = 32'h10;
    localparam logic [31:0] OFF_HIGH0   = 32'h14;
    localparam logic [31:0] CH_STRIDE   = 32'h08;
    typedef enum logic {IDLE = 1'b0, MEAS = 1'b1} chan_state_e;
endpackage

// File: rtl/pwm_cap_chan.sv
// pwm_cap_chan: one capture channel measuring period and high time of cap_i in clk cycles
module pwm_cap_chan
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_i,
    input  logic             en_i,
    input  logic             valid_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_set_o,
    output logic             miss_set_o,
    output logic             ovf_set_o
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    chan_state_e state_q, state_d;
    logic [2:0] sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, hi_q, hi_d, period_q, period_d, high_q, high_d, cnt_inc;
    logic rise, fall;
    always_comb begin
        sync_d = {sync_q[1:0], cap_i};
        rise = sync_q[1] & ~sync_q[2];
        fall = ~sync_q[1] & sync_q[2];
        cnt_inc = cnt_q + ONE;
        state_d = state_q;
        cnt_d = cnt_q;
        hi_d = hi_q;
        period_d = period_q;
        high_d = high_q;
        valid_set_o = 1'b0;
        ovf_set_o = 1'b0;
        if (!en_i) begin
            state_d = IDLE;
            cnt_d = '0;
            hi_d = '0;
        end else if (state_q == IDLE) begin
            cnt_d = '0;
            state_d = rise ? MEAS : IDLE;
        end else if (&cnt_q) begin
            ovf_set_o = 1'b1;
            state_d = IDLE;
            cnt_d = '0;
        end else if (rise) begin
            period_d = cnt_inc;
            high_d = hi_q;
            cnt_d = '0;
            valid_set_o = 1'b1;
        end else begin
            cnt_d = cnt_inc;
            hi_d = fall ? cnt_inc : hi_q;
        end
        miss_set_o = valid_set_o & valid_i;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q <= '0;
            cnt_q <= '0;
            hi_q <= '0;
            period_q <= '0;
            high_q <= '0;
        end else begin
            state_q <= state_d;
            sync_q <= sync_d;
            cnt_q <= cnt_d;
            hi_q <= hi_d;
            period_q <= period_d;
            high_q <= high_d;
        end
    end
    assign period_o = period_q;
    assign high_o = high_q;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: four-channel input capture with CTRL/STATUS registers, result read mux and level irq
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h6020_0000,
    parameter int          CNT_W     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] write_addr,
    input  logic [31:0] write_data,
    input  logic [31:0] read_addr,
    output logic [31:0] read_data,
    input  logic [3:0]  cap_in,
    output logic        irq_o
);
    logic [7:0] ctrl_q, ctrl_d;
    logic [11:0] status_q, status_d;
    logic irq_q, irq_d;
    logic [NCH-1:0] valid_set, miss_set, ovf_set;
    logic [CNT_W-1:0] period [NCH];
    logic [CNT_W-1:0] high [NCH];
    logic [31:0] woff, roff;
    logic unused_wd;
    assign unused_wd = ^write_data[31:12];
    always_comb begin
        woff = write_addr - BASE_ADDR;
        ctrl_d = (we_i && woff == OFF_CTRL) ? write_data[7:0] : ctrl_q;
        status_d = ((we_i && woff == OFF_STATUS) ? status_q & ~write_data[11:0] : status_q)
                   | {ovf_set, miss_set, valid_set};
        irq_d = |(status_q[3:0] & ctrl_q[7:4]);
    end
    // Channels see the next CTRL value so a disabling write beats a same-cycle rise.
    for (genvar n = 0; n < NCH; n++) begin : g_ch
        pwm_cap_chan #(.CNT_W(CNT_W)) u_chan (
            .clk         (clk),
            .rst         (rst),
            .cap_i       (cap_in[n]),
            .en_i        (ctrl_d[n]),
            .valid_i     (status_q[n]),
            .period_o    (period[n]),
            .high_o      (high[n]),
            .valid_set_o (valid_set[n]),
            .miss_set_o  (miss_set[n]),
            .ovf_set_o   (ovf_set[n])
        );
    end
    always_comb begin
        roff = read_addr - BASE_ADDR;
        read_data = '0;
        if (roff == OFF_CTRL) read_data = {24'b0, ctrl_q};
        if (roff == OFF_STATUS) read_data = {20'b0, status_q};
        for (int i = 0; i < NCH; i++) begin
            if (roff == OFF_PERIOD0 + CH_STRIDE * 32'(i)) read_data = 32'(period[i]);
            if (roff == OFF_HIGH0 + CH_STRIDE * 32'(i)) read_data = 32'(high[i]);
        end
        read_data = rst ? '0 : read_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
            status_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            status_q <= status_d;
            irq_q <= irq_d;
        end
    end
    assign irq_o = irq_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed self-checking bench for pwm_capture (CNT_W=8 build)
module tb_pwm_capture;
    localparam logic [31:0] BASE = 32'h6020_0000;
    logic clk = 1'b0;
    logic rst, we_i, irq_o;
    logic [31:0] write_addr, write_data, read_addr, read_data;
    logic [3:0] cap_in;
    int n_chk = 0;
    int n_fail = 0;

    pwm_capture #(.BASE_ADDR(BASE), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .we_i       (we_i),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .cap_in     (cap_in),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        int          hi;
        int          per;
        logic [31:0] exp_per;
        logic [31:0] exp_hi;
        logic [31:0] exp_status;
    } vec_t;
    vec_t vecs[7];
    logic [31:0] offs[10];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic rd(input string nm, input logic [31:0] off, input logic [31:0] exp);
        read_addr = BASE + off;
        #1;
        chk(nm, read_data, exp);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        we_i = 1'b1;
        write_addr = BASE + off;
        write_data = d;
        tick(1);
        we_i = 1'b0;
    endtask

    task automatic drive_wave(input int ch, input int hi, input int per, input int nper);
        for (int k = 0; k < nper; k++) begin
            cap_in[ch] = 1'b1;
            tick(hi);
            cap_in[ch] = 1'b0;
            tick(per - hi);
        end
    endtask

    task automatic cleanup();
        cap_in = '0;
        wr(32'h00, 32'h0);
        tick(3);
        wr(32'h04, 32'hFFF);
    endtask

    initial begin
        vecs = '{
            '{0, 3, 10, 32'd10, 32'd3, 32'h001},
            '{1, 5, 12, 32'd12, 32'd5, 32'h002},
            '{2, 2, 7, 32'd7, 32'd2, 32'h004},
            '{3, 1, 4, 32'd4, 32'd1, 32'h008},
            '{0, 9, 10, 32'd10, 32'd9, 32'h001},
            '{1, 1, 2, 32'd2, 32'd1, 32'h002},
            '{3, 100, 200, 32'd200, 32'd100, 32'h008}
        };
        offs = '{32'h00, 32'h04, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h28, 32'h2C};
        rst = 1'b1;
        we_i = 1'b0;
        cap_in = '0;
        write_addr = '0;
        write_data = '0;
        read_addr = BASE;
        #1;
        chk("read_during_reset", read_data, 32'h0);
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) rd($sformatf("reset_reg_%0h", offs[i]), offs[i], 32'h0);
        chk("reset_irq", {31'b0, irq_o}, 32'h0);
        wr(32'h10, 32'hFFFF_FFFF);
        wr(32'h08, 32'hFFFF_FFFF);
        rd("ro_write_period0", 32'h10, 32'h0);
        rd("unmapped_read", 32'h08, 32'h0);
        rd("ctrl_after_bad_writes", 32'h00, 32'h0);

        for (int v = 0; v < 7; v++) begin
            wr(32'h00, (32'h1 << vecs[v].ch) | (32'h10 << vecs[v].ch));
            drive_wave(vecs[v].ch, vecs[v].hi, vecs[v].per, 2);
            tick(3);
            rd($sformatf("vec%0d_period", v), 32'h10 + 32'(8 * vecs[v].ch), vecs[v].exp_per);
            rd($sformatf("vec%0d_high", v), 32'h14 + 32'(8 * vecs[v].ch), vecs[v].exp_hi);
            rd($sformatf("vec%0d_status", v), 32'h04, vecs[v].exp_status);
            chk($sformatf("vec%0d_irq", v), {31'b0, irq_o}, 32'h1);
            cleanup();
        end

        wr(32'h00, 32'h11);
        drive_wave(0, 3, 10, 1);
        cap_in[0] = 1'b1;
        tick(2);
        rd("basic_status_before", 32'h04, 32'h000);
        tick(1);
        rd("basic_status", 32'h04, 32'h001);
        rd("basic_period0", 32'h10, 32'd10);
        rd("basic_high0", 32'h14, 32'd3);
        chk("basic_irq_lag", {31'b0, irq_o}, 32'h0);
        tick(1);
        chk("basic_irq_set", {31'b0, irq_o}, 32'h1);
        wr(32'h04, 32'h1);
        rd("basic_w1c_status", 32'h04, 32'h000);
        chk("basic_irq_hold", {31'b0, irq_o}, 32'h1);
        tick(1);
        chk("basic_irq_clear", {31'b0, irq_o}, 32'h0);
        cleanup();

        wr(32'h00, 32'h04);
        drive_wave(2, 2, 7, 3);
        cap_in[2] = 1'b1;
        tick(3);
        rd("miss_period2", 32'h20, 32'd7);
        rd("miss_high2", 32'h24, 32'd2);
        rd("miss_status", 32'h04, 32'h044);
        cleanup();

        wr(32'h00, 32'h02);
        drive_wave(1, 2, 5, 1);
        cap_in[1] = 1'b1;
        tick(3);
        rd("ovf_first_period1", 32'h18, 32'd5);
        tick(255);
        rd("ovf_not_yet", 32'h04, 32'h002);
        tick(1);
        rd("ovf_status", 32'h04, 32'h202);
        rd("ovf_period1_kept", 32'h18, 32'd5);
        cap_in[1] = 1'b0;
        tick(3);
        drive_wave(1, 2, 6, 1);
        rd("ovf_rearm_only", 32'h18, 32'd5);
        cap_in[1] = 1'b1;
        tick(3);
        rd("ovf_recapture_period1", 32'h18, 32'd6);
        rd("ovf_recapture_high1", 32'h1C, 32'd2);
        cleanup();

        wr(32'h00, 32'h01);
        drive_wave(0, 3, 10, 1);
        cap_in[0] = 1'b1;
        tick(3);
        rd("coll_first_status", 32'h04, 32'h001);
        cap_in[0] = 1'b0;
        tick(4);
        cap_in[0] = 1'b1;
        tick(2);
        wr(32'h04, 32'h1);
        rd("coll_w1c_vs_set", 32'h04, 32'h011);
        rd("coll_period0", 32'h10, 32'd7);
        cleanup();

        wr(32'h00, 32'h08);
        drive_wave(3, 2, 6, 1);
        cap_in[3] = 1'b1;
        tick(3);
        wr(32'h04, 32'h8);
        cap_in[3] = 1'b0;
        tick(4);
        cap_in[3] = 1'b1;
        tick(2);
        wr(32'h00, 32'h0);
        tick(3);
        rd("dis_period3_kept", 32'h28, 32'd6);
        rd("dis_status", 32'h04, 32'h000);
        rd("dis_ctrl", 32'h00, 32'h000);
        cleanup();

        wr(32'h00, 32'h0F);
        fork
            drive_wave(0, 25, 100, 3);
            drive_wave(1, 10, 50, 6);
            drive_wave(2, 29, 30, 10);
            drive_wave(3, 8, 17, 17);
        join
        tick(3);
        rd("loop_period0", 32'h10, 32'd100);
        rd("loop_high0", 32'h14, 32'd25);
        rd("loop_period1", 32'h18, 32'd50);
        rd("loop_high1", 32'h1C, 32'd10);
        tick(1);
        rd("loop_period2", 32'h20, 32'd30);
        rd("loop_high2", 32'h24, 32'd29);
        rd("loop_period3", 32'h28, 32'd17);
        rd("loop_high3", 32'h2C, 32'd8);
        tick(1);
        rd("loop_status", 32'h04, 32'h0FF);

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        rd("midrst_period0", 32'h10, 32'h0);
        rd("midrst_status", 32'h04, 32'h0);
        rd("midrst_ctrl", 32'h00, 32'h0);
        chk("midrst_irq", {31'b0, irq_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Four-channel input-capture peripheral on the same 32-bit peripheral bus as PWM.
- Each channel measures period and high time of a digital input in clk cycles. Intended inputs are external signals, or pwm_out[3:0] of PWM for loopback self-test.
- Results and status are readable by the CPU. A level interrupt flags completed captures.

Parameters:
- BASE_ADDR, 32'h6020_0000, base of the register block (full 32-bit address compare).
- CNT_W, 32, counter/result width; results are zero-extended to 32 bits on read.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- we_i  in  1  write strobe, one cycle per write
- write_addr  in  32  write address
- write_data  in  32  write data
- read_addr  in  32  read address
- read_data  out  32  combinational read data; 0 for unmapped addresses
- cap_in  in  4  asynchronous capture inputs, bit n = channel n
- irq_o  out  1  interrupt, level, active-high

Behaviour:
- Register map (offsets from BASE_ADDR):
  - 0x00 CTRL RW: [3:0] EN, [7:4] IE.
  - 0x04 STATUS: [3:0] VALID, [7:4] MISS, [11:8] OVF. Reads return the value; writes are write-1-to-clear.
  - 0x10+8n PERIODn, RO.
  - 0x14+8n HIGHn, RO.
  - Writes to RO or unmapped addresses are ignored.
- Reset: CTRL, STATUS, all PERIOD/HIGH, counters and sync flops = 0. Every channel in IDLE. irq_o = 0, read_data = 0 for any address read during reset.
- Input path per channel:
  - 2-flop synchronizer s1→s2, plus history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - An edge on cap_in is acted on at the 3rd rising clk edge after it is sampled.
- Channel FSM:
  - IDLE: cnt=0. On rise with EN[n]=1 → MEAS, cnt←0.
  - MEAS: cnt←cnt+1 each cycle.
    - On fall: hi_tmp←cnt+1.
    - On rise: PERIODn←cnt+1, HIGHn←hi_tmp, cnt←0, set VALID[n]. If VALID[n] was already 1, also set MISS[n]. Stay in MEAS.
    - If cnt reaches all-ones without a rise: set OVF[n], go to IDLE, leave PERIODn/HIGHn unchanged.
  - EN[n] cleared at any time → IDLE next cycle, cnt and hi_tmp cleared, results and status kept.
- The first rise after enable only arms the channel. The first result appears at the second rise.
- Constant-high input in MEAS (no fall since the last rise): HIGHn = hi_tmp from the previous period. Software detects this case via OVF.
- Simultaneous events:
  - STATUS W1C and a hardware set of the same bit in the same cycle: the set wins.
  - Rise and a CTRL write clearing EN in the same cycle: the disable wins and no capture occurs.
- CTRL writes take effect the next cycle. Reading CTRL, STATUS or results returns post-update register values, i.e. one cycle after the write/capture.
- irq_o = |(VALID & IE), registered: asserts one cycle after VALID sets, deasserts one cycle after W1C.
- Reset asserted mid-measurement: everything returns to reset values on the next clk edge; no partial result is stored.

Decomposition:
- Shared package/include holds:
  - register offset constants (CTRL, STATUS, PERIOD/HIGH stride);
  - channel count 4;
  - FSM state encodings IDLE=1'b0, MEAS=1'b1.
- Sub-module pwm_cap_chan: synchronizer, edge detect, FSM, cnt, hi_tmp, PERIOD/HIGH registers, and set pulses for VALID/MISS/OVF. Instantiated 4× by pwm_capture.
- The top level holds CTRL, STATUS, W1C logic, read mux and irq.

Test Plan:
- Reset check: assert rst 2 cycles → every register reads 0 and irq_o=0. A write to PERIOD0 has no effect (reads 0).
- Basic capture: CTRL=0x11, cap_in[0] toggles with high 3 cycles and period 10 → after 2nd rise PERIOD0=10, HIGH0=3, STATUS=0x001, irq_o=1 one cycle later. Write STATUS=0x1 → STATUS=0, irq_o=0.
- MISS: leave VALID[2] uncleared across two further periods of a 7/2 waveform → PERIOD2=7, HIGH2=2, STATUS=0x044.
- Overflow: CNT_W=8 build, cap_in[1] held high after arming rise → after 255 cycles STATUS[9]=1, channel re-arms only on a new rise, PERIOD1 unchanged.
- Collision: W1C of VALID[0] in the same cycle as a new capture → VALID[0] remains 1. Clear EN[3] in the rise cycle → no update to PERIOD3.
- Loopback: drive cap_in from PWM pwm_out with A0=99, B0=25, C[0]=1 → PERIOD0=100, HIGH0=25 on every capture; all 4 channels run concurrently with independent values.
